// File: rtl/logic_display_scan_ctrl.sv
// logic_display_scan_ctrl
// ---------------------------------------------------------------------------
// Capture-and-render sequencer for the 4-channel logic analyzer display.
// An arm pulse starts an acquisition. The block then waits for a rising or
// falling edge on the selected probe channel and records DEPTH (88) 4-bit
// samples into a register buffer. It then scans the 96x64 panel row-major,
// presenting one pixel at a time to the OLED driver over valid/ready.
//
// Ports
//   clk, rst           : system clock, asynchronous active-high reset
//   probe_in[3:0]      : probe channels (already synchronous to clk)
//   sample_tick        : one-cycle capture strobe
//   arm                : starts an acquisition from IDLE
//   trig_ch[1:0]       : channel watched for the trigger edge
//   trig_rise          : 1 = rising-edge trigger, 0 = falling-edge trigger
//   px_x/px_y          : current pixel column/row
//   px_sample[3:0]     : buffer entry for column px_x (0 inside label zone)
//   px_valid/px_ready  : pixel handshake towards the driver
//   frame_start        : high with pixel (0,0) until it is accepted
//   frame_done         : one-cycle pulse on acceptance of the last pixel
//   busy               : high in ARMED, CAPTURE and RENDER
//
// Build option
//   LA_AUTO_REARM_EN   : when defined, the block re-enters ARMED after each
//                        frame and loops continuously. When undefined, it
//                        returns to IDLE and needs a new arm pulse.
// ---------------------------------------------------------------------------
module logic_display_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] probe_in,
  input  logic       sample_tick,
  input  logic       arm,
  input  logic [1:0] trig_ch,
  input  logic       trig_rise,
  output logic [6:0] px_x,
  output logic [5:0] px_y,
  output logic [3:0] px_sample,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;
  localparam int LABEL_W  = 8;
  localparam int DEPTH    = SCREEN_W - LABEL_W;

  localparam logic [6:0] X_LAST   = 7'(SCREEN_W - 1);
  localparam logic [5:0] Y_LAST   = 6'(SCREEN_H - 1);
  localparam logic [6:0] X_LABEL  = 7'(LABEL_W);
  localparam logic [6:0] WR_LAST  = 7'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RENDER  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic [6:0] wr_idx_q, wr_idx_d;
  logic [6:0] px_x_q, px_x_d;
  logic [5:0] px_y_q, px_y_d;
  logic [3:0] px_sample_q, px_sample_d;
  logic       px_valid_q, px_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;

  // Sample buffer: not reset, only meaningful once a capture has completed.
  logic [3:0] buf_q [DEPTH];
  logic       buf_we_s;
  logic [6:0] buf_waddr_s;
  logic [3:0] buf_wdata_s;

  // Pixel that follows the one currently presented.
  logic [6:0] nx_x_s;
  logic [5:0] nx_y_s;
  logic [6:0] rd_idx_s;
  logic [3:0] nx_sample_s;

  logic       trig_now_s;
  logic       trig_edge_s;
  logic       last_px_s;
  logic       accept_s;

  // Trigger edge detection on the selected channel.
  always_comb begin
    trig_now_s = probe_in[trig_ch];
    if (trig_rise) begin
      trig_edge_s = !prev_q && trig_now_s;
    end else begin
      trig_edge_s = prev_q && !trig_now_s;
    end
  end

  // Next scan position and the buffer entry that belongs to it.
  always_comb begin
    if (px_x_q == X_LAST) begin
      nx_x_s = 7'd0;
      nx_y_s = px_y_q + 6'd1;
    end else begin
      nx_x_s = px_x_q + 7'd1;
      nx_y_s = px_y_q;
    end
    if (nx_x_s >= X_LABEL) begin
      rd_idx_s    = nx_x_s - X_LABEL;
      nx_sample_s = buf_q[rd_idx_s];
    end else begin
      rd_idx_s    = 7'd0;
      nx_sample_s = 4'h0;
    end
    last_px_s = (px_x_q == X_LAST) && (px_y_q == Y_LAST);
    accept_s  = px_valid_q && px_ready;
  end

  // Next-state and output-register logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    wr_idx_d      = wr_idx_q;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    px_sample_d   = px_sample_q;
    px_valid_d    = px_valid_q;
    frame_start_d = frame_start_q;
    frame_done_d  = 1'b0;
    buf_we_s      = 1'b0;
    buf_waddr_s   = wr_idx_q;
    buf_wdata_s   = probe_in;

    case (state_q)
      S_IDLE: begin
        prev_valid_d = 1'b0;
        wr_idx_d     = 7'd0;
        if (arm) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ARMED: begin
        if (sample_tick) begin
          prev_d       = trig_now_s;
          prev_valid_d = 1'b1;
          // The first tick after arming only primes prev, so it can never fire.
          if (prev_valid_q && trig_edge_s) begin
            buf_we_s    = 1'b1;
            buf_waddr_s = 7'd0;
            wr_idx_d    = 7'd1;
            state_d     = S_CAPTURE;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          state_d = S_ARMED;
        end
      end

      S_CAPTURE: begin
        if (sample_tick) begin
          buf_we_s = 1'b1;
          wr_idx_d = wr_idx_q + 7'd1;
          if (wr_idx_q == WR_LAST) begin
            // Buffer full: present (0,0) on the very next cycle.
            state_d       = S_RENDER;
            wr_idx_d      = 7'd0;
            px_x_d        = 7'd0;
            px_y_d        = 6'd0;
            px_sample_d   = 4'h0;
            px_valid_d    = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_RENDER: begin
        if (accept_s) begin
          frame_start_d = 1'b0;
          if (last_px_s) begin
            px_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            px_x_d       = 7'd0;
            px_y_d       = 6'd0;
            px_sample_d  = 4'h0;
            prev_valid_d = 1'b0;
`ifdef LA_AUTO_REARM_EN
            state_d      = S_ARMED;
`else
            state_d      = S_IDLE;
`endif
          end else begin
            px_x_d      = nx_x_s;
            px_y_d      = nx_y_s;
            px_sample_d = nx_sample_s;
            state_d     = S_RENDER;
          end
        end else begin
          state_d = S_RENDER;
        end
      end

      default: begin
        state_d       = S_IDLE;
        prev_valid_d  = 1'b0;
        wr_idx_d      = 7'd0;
        px_valid_d    = 1'b0;
        frame_start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      prev_q        <= 1'b0;
      prev_valid_q  <= 1'b0;
      wr_idx_q      <= 7'd0;
      px_x_q        <= 7'd0;
      px_y_q        <= 6'd0;
      px_sample_q   <= 4'h0;
      px_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      wr_idx_q      <= wr_idx_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_sample_q   <= px_sample_d;
      px_valid_q    <= px_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[buf_waddr_s] <= buf_wdata_s;
    end
  end

  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_sample   = px_sample_q;
  assign px_valid    = px_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_logic_display_scan_ctrl.sv
// Self-checking bench for logic_display_scan_ctrl. Expected pixels are pushed
// to a scoreboard queue when the capture stimulus completes and are popped
// as the DUT hands pixels over.
module tb_logic_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] probe_in;
  logic       sample_tick;
  logic       arm;
  logic [1:0] trig_ch;
  logic       trig_rise;
  logic [6:0] px_x;
  logic [5:0] px_y;
  logic [3:0] px_sample;
  logic       px_valid;
  logic       px_ready;
  logic       frame_start;
  logic       frame_done;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  mbuf [88];
  logic [16:0] exp_q [$];

`ifdef LA_AUTO_REARM_EN
  localparam logic EXP_BUSY_AFTER = 1'b1;
`else
  localparam logic EXP_BUSY_AFTER = 1'b0;
`endif

  logic_display_scan_ctrl dut (
    .clk(clk), .rst(rst), .probe_in(probe_in), .sample_tick(sample_tick),
    .arm(arm), .trig_ch(trig_ch), .trig_rise(trig_rise),
    .px_x(px_x), .px_y(px_y), .px_sample(px_sample), .px_valid(px_valid),
    .px_ready(px_ready), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; probe_in = 4'h0; sample_tick = 1'b0; arm = 1'b0;
    trig_ch = 2'd0; trig_rise = 1'b1; px_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick(input logic [3:0] v);
    probe_in = v; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Stores the remaining 87 samples after a trigger and pushes the expected frame.
  task automatic capture_rest(input logic [3:0] start, input bit arm_mid);
    logic [3:0] v;
    for (int i = 1; i < 88; i++) begin
      if (arm_mid && i == 40) pulse_arm();
      if (i == 87) begin
        n_checks++;
        if (px_valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL early_render px_valid=%b busy=%b required px_valid=0 busy=1", px_valid, busy);
        else n_pass++;
      end
      v = start + 4'(i - 1);
      mbuf[i] = v;
      tick(v);
    end
    n_checks++;
    if ({px_valid, frame_start, px_x, px_y, px_sample} !== {1'b1, 1'b1, 7'd0, 6'd0, 4'h0})
      $display("FAIL render_entry valid=%b fs=%b x=%0d y=%0d s=%h required 1 1 0 0 0",
               px_valid, frame_start, px_x, px_y, px_sample);
    else n_pass++;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 96; x++)
        exp_q.push_back({7'(x), 6'(y), (x < 8) ? 4'h0 : mbuf[x - 8]});
  endtask

  // Accepts a whole frame; optionally stalls 5 cycles at (stall_x, stall_y).
  task automatic run_render(input int stall_x, input int stall_y);
    int cyc, since, accepted, stall_cyc;
    bit done, stalled;
    logic [16:0] e, snap;
    logic snap_fs;
    cyc = 0; since = -1; accepted = 0; stall_cyc = 0; done = 0; stalled = 0;
    px_ready = 1'b1;
    while (!done && cyc < 7000) begin
      if (frame_done) begin
        n_checks++;
        if (since != 6144 + stall_cyc || accepted != 6144 || exp_q.size() != 0 || px_valid !== 1'b0)
          $display("FAIL frame_done_timing cycles=%0d accepted=%0d left=%0d valid=%b required cycles=%0d accepted=6144 left=0 valid=0",
                   since, accepted, exp_q.size(), px_valid, 6144 + stall_cyc);
        else n_pass++;
        done = 1;
      end else if (px_valid) begin
        if (since < 0) since = 0;
        if (!stalled && px_x == 7'(stall_x) && px_y == 6'(stall_y)) begin
          stalled = 1; snap = {px_x, px_y, px_sample}; snap_fs = frame_start;
          px_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk); cyc++; since++; stall_cyc++;
            n_checks++;
            if ({px_valid, frame_start, px_x, px_y, px_sample} !== {1'b1, snap_fs, snap} || frame_done !== 1'b0)
              $display("FAIL stall_hold cyc=%0d got=%b%b%h fd=%b required=1%b%h fd=0",
                       k, px_valid, frame_start, {px_x, px_y, px_sample}, frame_done, snap_fs, snap);
            else n_pass++;
          end
          px_ready = 1'b1;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pixel_extra got x=%0d y=%0d required none", px_x, px_y);
        end else begin
          e = exp_q.pop_front();
          if ({px_x, px_y, px_sample} !== e || frame_start !== (accepted == 0))
            $display("FAIL pixel got x=%0d y=%0d s=%h fs=%b required x=%0d y=%0d s=%h fs=%b",
                     px_x, px_y, px_sample, frame_start, e[16:10], e[9:4], e[3:0], (accepted == 0));
          else n_pass++;
        end
        accepted++;
      end else if (since >= 0) begin
        n_checks++;
        $display("FAIL valid_dropped after %0d accepted required px_valid=1", accepted);
        done = 1;
      end
      if (!done) begin
        @(negedge clk); cyc++;
        if (since >= 0) since++;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL render_timeout accepted=%0d required frame_done within 7000 cycles", accepted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; probe_in = 4'h0; sample_tick = 1'b0; arm = 1'b0;
    trig_ch = 2'd0; trig_rise = 1'b1; px_ready = 1'b0;
    #1;
    n_checks++;
    if ({px_x, px_y, px_sample} !== 17'd0)
      $display("FAIL reset_pos x=%0d y=%0d s=%h required 0 0 0", px_x, px_y, px_sample);
    else n_pass++;
    n_checks++;
    if ({px_valid, frame_start, frame_done, busy} !== 4'b0000)
      $display("FAIL reset_flags got=%b required=0000", {px_valid, frame_start, frame_done, busy});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_rise_capture_frame();
    do_reset();
    trig_ch = 2'd2; trig_rise = 1'b1;
    pulse_arm();
    n_checks++;
    if (busy !== 1'b1 || px_valid !== 1'b0)
      $display("FAIL arm_busy busy=%b valid=%b required busy=1 valid=0", busy, px_valid);
    else n_pass++;
    tick(4'h0);
    tick(4'h4);
    mbuf[0] = 4'h4;
    capture_rest(4'h5, 1'b1);
    run_render(-1, -1);
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0 || px_valid !== 1'b0 || busy !== EXP_BUSY_AFTER)
      $display("FAIL after_frame fd=%b valid=%b busy=%b required fd=0 valid=0 busy=%b",
               frame_done, px_valid, busy, EXP_BUSY_AFTER);
    else n_pass++;
  endtask

  task automatic test_fall_backpressure();
    do_reset();
    trig_ch = 2'd2; trig_rise = 1'b0;
    probe_in = 4'h4;
    @(negedge clk);
    pulse_arm();
    tick(4'h0);   // falls from pre-arm value: first tick only primes
    tick(4'h4);   // rise: not a falling trigger
    tick(4'h0);   // fall: trigger, stored as buf[0]
    mbuf[0] = 4'h0;
    capture_rest(4'h9, 1'b0);
    run_render(95, 3);
  endtask

  task automatic test_reset_mid_render();
    int cyc;
    do_reset();
    trig_ch = 2'd1; trig_rise = 1'b1;
    pulse_arm();
    tick(4'h0);
    tick(4'h2);
    mbuf[0] = 4'h2;
    capture_rest(4'h3, 1'b0);
    exp_q.delete();
    px_ready = 1'b1;
    cyc = 0;
    while (!(px_valid && px_x == 7'd40 && px_y == 6'd10) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (!(px_valid && px_x == 7'd40 && px_y == 6'd10)) begin
      $display("FAIL reach_40_10 x=%0d y=%0d valid=%b required x=40 y=10 valid=1", px_x, px_y, px_valid);
    end else n_pass++;
    px_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({px_valid, px_x, px_y, busy, frame_done, frame_start} !== 17'd0)
      $display("FAIL async_reset valid=%b x=%0d y=%0d busy=%b fd=%b fs=%b required all 0",
               px_valid, px_x, px_y, busy, frame_done, frame_start);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tick(4'h0);
    tick(4'h2);
    tick(4'h0);
    tick(4'h2);
    n_checks++;
    if (busy !== 1'b0 || px_valid !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL idle_after_reset busy=%b valid=%b fd=%b required 0 0 0", busy, px_valid, frame_done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rise_capture_frame();
    test_fall_backpressure();
    test_reset_mid_render();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/logic_display_scan_ctrl.md
# logic_display_scan_ctrl

Capture-and-render sequencer for the 4-channel logic analyzer display. It arms on command and waits for an edge on a selected probe channel. It then records one screen-width of 4-bit samples into an internal buffer and scans the 96x64 RGB565 panel row-major, driving the pixel generator's x/y/sample inputs. Pixels are handed to the OLED driver over a valid/ready handshake.

## Interface
- SCREEN_W, 96: panel width in pixels; x width 7 bits
- SCREEN_H, 64: panel height in pixels; y width 6 bits
- LABEL_W, 8: left label-zone width; buffer depth DEPTH = SCREEN_W - LABEL_W = 88
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- probe_in  in  4  probe channels, already synchronous to clk
- sample_tick  in  1  one-cycle capture strobe; sampling occurs only when high
- arm  in  1  pulse; starts an acquisition from IDLE
- trig_ch  in  2  channel index watched for trigger
- trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- px_x  out  7  current pixel column, 0..SCREEN_W-1
- px_y  out  6  current pixel row, 0..SCREEN_H-1
- px_sample  out  4  buffer entry for column px_x; 0 when px_x < LABEL_W
- px_valid  out  1  px_x/px_y/px_sample hold a pixel for the driver
- px_ready  in  1  driver accepts pixel when px_valid && px_ready
- frame_start  out  1  high with the (0,0) pixel until it is accepted
- frame_done  out  1  one-cycle pulse on acceptance of (SCREEN_W-1, SCREEN_H-1)
- busy  out  1  high in ARMED, CAPTURE, RENDER

## Operation
- States: IDLE, ARMED, CAPTURE, RENDER.
- IDLE:
  - arm=1 -> ARMED next cycle.
  - prev_valid is cleared.
- ARMED:
  - Each sample_tick loads prev = probe_in[trig_ch] and sets prev_valid.
  - Trigger fires on a sample_tick when prev_valid=1 and the edge matches: prev=0 and now=1 for trig_rise=1; prev=1 and now=0 for trig_rise=0.
  - The first tick after arming only loads prev and cannot trigger.
  - On trigger, probe_in is written to buf[0], wr_idx=1, state -> CAPTURE.
- CAPTURE:
  - Each sample_tick writes probe_in to buf[wr_idx] and increments wr_idx.
  - The write with wr_idx = DEPTH-1 completes the buffer and moves the state to RENDER.
- RENDER:
  - Scan order is row-major, x incrementing fastest: (0,0), (1,0) … (95,0), (0,1) … (95,63).
  - px_sample = buf[px_x - LABEL_W] for px_x >= LABEL_W, else 4'h0.
  - The next pixel loads on acceptance. When x wraps to 0, y increments.
  - Acceptance of (95,63) pulses frame_done, deasserts px_valid the same edge, and takes the exit transition (see Configuration).
- arm is ignored outside IDLE. sample_tick is ignored in IDLE and RENDER. trig_ch/trig_rise are sampled every tick in ARMED and must be held stable by the user.
- Buffer is a register array, not reset; its contents are only meaningful after CAPTURE completes.

## Timing
- Reset values: px_x=0, px_y=0, px_sample=0, px_valid=0, frame_start=0, frame_done=0, busy=0, state=IDLE, wr_idx=0, prev_valid=0.
- All outputs are registered.
- arm at edge N: busy=1 after edge N.
- Last capture write at edge N: px_valid=1, px_x=0, px_y=0, frame_start=1 after edge N.
- Handshake:
  - While px_valid && !px_ready, px_x/px_y/px_sample/frame_start hold stable.
  - px_valid never drops before acceptance.
  - Acceptance at edge N presents the next pixel after edge N, giving throughput of 1 pixel/cycle with px_ready held high.
- frame_start clears on the edge that accepts (0,0).
- Full frame with px_ready=1 throughout: 6144 cycles from first px_valid to frame_done.
- Trigger and the first capture write happen in the same cycle; latency from trigger tick to RENDER entry = DEPTH sample_ticks.
- Async reset mid-CAPTURE or mid-RENDER: outputs take reset values immediately. No frame_done is issued.

## Configuration
- LA_AUTO_REARM_EN defined:
  - After frame_done, state -> ARMED with prev_valid cleared; busy stays 1.
  - Continuous acquire/render loop with no further arm pulses.
- Undefined:
  - After frame_done, state -> IDLE and busy=0.
  - Each acquisition needs a new arm pulse.

## Test plan
- Reset asserted mid-RENDER at pixel (40,10) -> px_valid=0, px_x=0, px_y=0, busy=0 in the same cycle. After release, state is IDLE.
- arm, trig_ch=2, trig_rise=1; ticks with probe_in = 4'h0, 4'h4, then 87 ticks counting 4'h5.. -> trigger on 2nd tick. buf[0]=4'h4. RENDER begins after the 88th stored sample with frame_start=1 at (0,0).
- Same trigger setup with trig_rise=0 and probe_in[2] rising then falling -> no trigger on the rise, trigger on the fall. First tick after arm never triggers even if probe_in[2] toggles from its pre-arm value.
- px_ready=1 constantly -> 6144 accepted pixels in row-major order; px_sample=0 for x<8, buf[x-8] for x>=8; frame_done pulses once with (95,63).
- px_ready low for 5 cycles at pixel (95,3) -> outputs stable for all 5 cycles. On acceptance the next pixel is (0,4).
- arm pulsed during CAPTURE -> ignored. After frame_done, state is IDLE and busy=0 without LA_AUTO_REARM_EN, or ARMED and busy=1 with it.
